time_set_ctrl: RTL
==================

# time_set_ctrl

Sequencing controller for the hours/minutes/seconds timekeeping datapath on the DE2 board. It generates the 1 Hz advance tick from CLOCK_50 and runs a key-driven set-time state machine. The machine freezes timekeeping, lets the user step hours and then minutes, and commits the edited values with a single load strobe. It also drives blink masks so the display layer can flash the field being edited.

## Interface
Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per 1 Hz tick (≥2)
- DEB_CYCLES, 500000, cycles a synchronized key level must differ from the accepted level before it is accepted (≥1)
- BLINK_DIV, 12500000, cycles per blink phase (≥1)

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge
- KEY0  input  1  asynchronous active-low reset
- mode_n  input  1  raw active-low mode key, asynchronous to CLOCK_50
- inc_n  input  1  raw active-low increment key, asynchronous to CLOCK_50
- cur_hours  input  5  current hours from datapath
- cur_minutes  input  6  current minutes from datapath
- tick  output  1  one-cycle advance pulse to datapath
- load  output  1  one-cycle commit strobe; datapath loads hours/minutes and clears seconds
- load_hours  output  5  committed hours, 0..23
- load_minutes  output  6  committed minutes, 0..59
- setting  output  1  high in SET_H, SET_M and COMMIT
- blink_hours  output  1  blank hours digits when high
- blink_minutes  output  1  blank minutes digits when high

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer with its own counter.
  - Counter increments while the synchronized level differs from the accepted level. It clears when they match.
  - When the counter reaches DEB_CYCLES−1 while the levels still differ, the accepted level flips and the counter clears.
  - A 1→0 flip of the accepted level produces a one-cycle press pulse. Release (0→1) produces no pulse.
- FSM states: RUN, SET_H, SET_M, COMMIT.
- RUN:
  - Prescaler counts 0..TICK_DIV−1 and wraps. tick=1 in the cycle the count equals TICK_DIV−1.
  - A mode press captures edit_h and edit_m and moves to SET_H. edit_h = cur_hours, or 0 if cur_hours>23. edit_m = cur_minutes, or 0 if cur_minutes>59.
  - An inc press in RUN is ignored.
- SET_H:
  - inc press: edit_h = (edit_h==23) ? 0 : edit_h+1.
  - mode press: move to SET_M.
- SET_M:
  - inc press: edit_m = (edit_m==59) ? 0 : edit_m+1.
  - mode press: move to COMMIT.
- COMMIT: lasts exactly one cycle, then unconditionally moves to RUN.
- load_hours and load_minutes are registered in the cycle that enters COMMIT, so load=1 and the values are valid together during COMMIT. Both hold their value afterwards.
- load=1 only in COMMIT. tick=0 in every non-RUN state.
- Prescaler is held at 0 outside RUN.
- Mode and inc press in the same cycle: the mode press takes effect and the inc press is discarded.
- Blink counter and phase clear on every state entry.
  - In SET_H and SET_M the counter runs, and phase toggles every BLINK_DIV cycles, starting at 0 (visible).
  - blink_hours = phase in SET_H. blink_minutes = phase in SET_M. Both are 0 otherwise.

## Timing
- Reset (KEY0 low, asynchronous) sets:
  - state RUN, prescaler 0, tick 0, load 0
  - load_hours 0, load_minutes 0, edit_h 0, edit_m 0
  - setting 0, blink counter/phase/outputs 0
  - synchronizer flops and accepted key levels 1 (released), debounce counters 0
- Reset mid-edit discards edits and does not pulse load.
- Key latency with a clean edge: the press pulse is high 2+DEB_CYCLES cycles after the first edge that samples the key low. The FSM acts on the pulse in that same cycle.
- A bounce shorter than DEB_CYCLES cycles produces no pulse.
- Post-commit tick phase: first tick occurs TICK_DIV cycles after the COMMIT cycle, and every TICK_DIV cycles thereafter.
- State-to-output timing:
  - setting is high the cycle after the mode press that leaves RUN.
  - setting is low the cycle after COMMIT.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, TICK_DIV=4: after KEY0 rises, tick pulses on cycles 4, 8, 12, …. load and blink outputs stay 0.
- Set sequence, DEB_CYCLES=2, cur_hours=22, cur_minutes=58:
  - Stimulus: mode, inc, inc, mode, inc, inc, mode.
  - Required: a single load pulse with load_hours=0 and load_minutes=0. setting is high throughout the sequence, and tick is absent while setting is high.
- Out-of-range capture: cur_hours=27 and cur_minutes=63 at the mode press, then mode, mode → load_hours=0, load_minutes=0.
- Bounce, DEB_CYCLES=4: inc_n low for 3 cycles then high, repeated in SET_H → edit_h unchanged. One 10-cycle low pulse → edit_h +1 exactly once.
- Simultaneous presses in SET_H: mode and inc pulses in the same cycle → state goes to SET_M and edit_h is unchanged.
- Blink and reset, BLINK_DIV=3:
  - In SET_M, blink_minutes reads 0,0,0,1,1,1,0… and blink_hours stays 0.
  - Assert KEY0 mid-SET_M → all outputs return to reset values immediately, and no load pulse occurs.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Set-time controller for the DE2 clock: 1 Hz tick prescaler, debounced keys,
// and a RUN/SET_H/SET_M/COMMIT edit machine with blink masks.

module time_set_key_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                // accepted level flips; only the falling flip is a press
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module time_set_ctrl #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned BLINK_DIV  = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       mode_n,
    input  logic       inc_n,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       tick,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic       setting,
    output logic       blink_hours,
    output logic       blink_minutes
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [4:0]    edit_h;
    logic [5:0]    edit_m;
    logic          mode_press;
    logic          inc_press;
    logic          blink_wrap;
    logic          phase_next;

    time_set_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .key_n (mode_n),
        .press (mode_press)
    );

    time_set_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .key_n (inc_n),
        .press (inc_press)
    );

    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign phase_next = blink_phase ^ blink_wrap;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state         <= RUN;
            presc         <= '0;
            tick          <= 1'b0;
            load          <= 1'b0;
            load_hours    <= '0;
            load_minutes  <= '0;
            edit_h        <= '0;
            edit_m        <= '0;
            setting       <= 1'b0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
            blink_hours   <= 1'b0;
            blink_minutes <= 1'b0;
        end else begin
            tick <= 1'b0;
            load <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_press) begin
                        state         <= SET_H;
                        presc         <= '0;
                        setting       <= 1'b1;
                        edit_h        <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                        edit_m        <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                        blink_cnt     <= '0;
                        blink_phase   <= 1'b0;
                        blink_hours   <= 1'b0;
                        blink_minutes <= 1'b0;
                    end else begin
                        // tick is registered one count early so it lines up with PRESC_LAST
                        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                        tick  <= (presc == PRESC_PRE);
                    end
                end
                SET_H, SET_M: begin
                    if (mode_press) begin
                        blink_cnt     <= '0;
                        blink_phase   <= 1'b0;
                        blink_hours   <= 1'b0;
                        blink_minutes <= 1'b0;
                        if (state == SET_H) begin
                            state <= SET_M;
                        end else begin
                            state        <= COMMIT;
                            load         <= 1'b1;
                            load_hours   <= edit_h;
                            load_minutes <= edit_m;
                        end
                    end else begin
                        if (inc_press) begin
                            if (state == SET_H)
                                edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
                            else
                                edit_m <= (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
                        end
                        blink_cnt     <= blink_wrap ? '0 : blink_cnt + 1'b1;
                        blink_phase   <= phase_next;
                        blink_hours   <= (state == SET_H) && phase_next;
                        blink_minutes <= (state == SET_M) && phase_next;
                    end
                end
                default: begin
                    state         <= RUN;
                    presc         <= '0;
                    setting       <= 1'b0;
                    blink_cnt     <= '0;
                    blink_phase   <= 1'b0;
                    blink_hours   <= 1'b0;
                    blink_minutes <= 1'b0;
                end
            endcase
        end
    end
endmodule
